mux_arb_n: RTL and testbench

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel. It is the sequential successor to the fixed 2- and 4-input combinational muxes. Its main use is sharing a single downstream port among several requesters, such as instruction fetch, data access and debug sharing one memory or bus port. Selection comes from an internal arbiter, which runs in fixed-priority or round-robin mode, rather than from a select input.

---
 rtl/mux_arb_n.sv | 108 ++++++++++
 tb/tb_mux_arb_n.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel, W-bit arbitrating multiplexer with a registered output
// stage. The internal arbiter is fixed-priority (RR=0) or round-robin (RR=1),
// and every channel has a valid/ready handshake.
module mux_arb_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned RR    = 0,
  localparam int unsigned SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             any_gnt;
  logic [SELW-1:0]  base;
  logic [SELW:0]    cand;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid_q || out_ready;

  // Arbiter: search upward from base (0 for fixed priority, ptr for
  // round-robin) and wrap at NCH. One extra bit on cand keeps the wrap exact
  // when NCH is not a power of two.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    base    = (RR != 0) ? ptr_q : '0;
    for (int k = 0; k < int'(NCH); k++) begin
      cand = {1'b0, base} + (SELW+1)'(k);
      if (cand >= (SELW+1)'(NCH)) begin
        cand = cand - (SELW+1)'(NCH);
      end
      if (!any_gnt && in_valid[cand[SELW-1:0]]) begin
        any_gnt                = 1'b1;
        gnt_idx                = cand[SELW-1:0];
        gnt[cand[SELW-1:0]]    = 1'b1;
      end
    end
  end

  assign sel_data = in_data[gnt_idx*WIDTH +: WIDTH];

  // Ready follows the grant only when the output register can load. It is
  // forced low while reset is asserted, because load_en alone would be high then.
  always_comb begin
    in_ready = '0;
    if (load_en && rst_n) begin
      in_ready = gnt;
    end
  end

  // Next state of the output register and the round-robin pointer
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (any_gnt) begin
        out_data_d  = sel_data;
        out_sel_d   = gnt_idx;
        out_valid_d = 1'b1;
        if (RR != 0) begin
          ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a fixed-priority 4-channel instance and a
// round-robin 3-channel instance share the clock and reset.
module tb_mux_arb_n;

  logic clk;
  logic rst_n;

  // Fixed priority instance (NCH=4)
  logic [127:0] fp_in_data;
  logic [3:0]   fp_in_valid;
  logic [3:0]   fp_in_ready;
  logic [31:0]  fp_out_data;
  logic [1:0]   fp_out_sel;
  logic         fp_out_valid;
  logic         fp_out_ready;

  // Round-robin instance (NCH=3)
  logic [95:0]  rr_in_data;
  logic [2:0]   rr_in_valid;
  logic [2:0]   rr_in_ready;
  logic [31:0]  rr_out_data;
  logic [1:0]   rr_out_sel;
  logic         rr_out_valid;
  logic         rr_out_ready;

  int total;
  int bad;

  mux_arb_n #(.WIDTH(32), .NCH(4), .RR(0)) u_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (fp_in_data),
    .in_valid  (fp_in_valid),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_valid (fp_out_valid),
    .out_ready (fp_out_ready)
  );

  mux_arb_n #(.WIDTH(32), .NCH(3), .RR(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (rr_in_data),
    .in_valid  (rr_in_valid),
    .in_ready  (rr_in_ready),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_valid (rr_out_valid),
    .out_ready (rr_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    fp_in_valid  = '0;
    rr_in_valid  = '0;
    fp_out_ready = 1'b1;
    rr_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    fp_in_valid  = 4'b1111;
    rr_in_valid  = 3'b111;
    fp_out_ready = 1'b1;
    rr_out_ready = 1'b1;
    fp_in_data   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    rr_in_data   = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    repeat (2) @(negedge clk);
    total++;
    if (fp_out_valid !== 1'b0 || fp_out_data !== 32'h0 || fp_out_sel !== 2'd0 ||
        fp_in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_fp: valid=%b data=%h sel=%0d rdy=%b want 0/0/0/0000",
               fp_out_valid, fp_out_data, fp_out_sel, fp_in_ready);
    end
    total++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 || rr_out_sel !== 2'd0 ||
        rr_in_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset_rr: valid=%b data=%h sel=%0d rdy=%b want 0/0/0/000",
               rr_out_valid, rr_out_data, rr_out_sel, rr_in_ready);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd0 || fp_out_data !== 32'h1111_1111) begin
      bad++;
      $display("FAIL reset_first_fp: valid=%b sel=%0d data=%h want 1/0/11111111",
               fp_out_valid, fp_out_sel, fp_out_data);
    end
    total++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 32'h0000_00C0) begin
      bad++;
      $display("FAIL reset_first_rr: valid=%b sel=%0d data=%h want 1/0/000000c0",
               rr_out_valid, rr_out_sel, rr_out_data);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    fp_in_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    fp_in_valid = 4'b1010;
    #1;
    total++;
    if (fp_in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL fp_ready_comb: got %b want 0010", fp_in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 32'h1111_1111 ||
          fp_in_ready !== 4'b0010) begin
        bad++;
        $display("FAIL fp_cycle%0d: valid=%b sel=%0d data=%h rdy=%b want 1/1/11111111/0010",
                 c, fp_out_valid, fp_out_sel, fp_out_data, fp_in_ready);
      end
    end
    fp_in_valid = '0;
  endtask

  task automatic test_rr_rotation();
    logic [1:0] exp_a [6];
    logic [1:0] exp_b [4];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    exp_b = '{2'd1, 2'd2, 2'd1, 2'd2};
    do_reset();
    rr_in_data  = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    rr_in_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== exp_a[c] ||
          rr_out_data !== (32'h0000_00C0 + 32'(exp_a[c]))) begin
        bad++;
        $display("FAIL rr_rot%0d: valid=%b sel=%0d data=%h want sel %0d", c,
                 rr_out_valid, rr_out_sel, rr_out_data, exp_a[c]);
      end
    end
    rr_in_valid = 3'b110;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== exp_b[c]) begin
        bad++;
        $display("FAIL rr_drop0_%0d: valid=%b sel=%0d want 1/%0d", c,
                 rr_out_valid, rr_out_sel, exp_b[c]);
      end
    end
    rr_in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rr_in_data  = {32'hA5A5_A5A5, 32'h0000_00C1, 32'h0000_00C0};
    rr_in_valid = 3'b100;
    step();
    rr_out_ready = 1'b0;
    rr_in_valid  = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hA5A5_A5A5 || rr_out_sel !== 2'd2 ||
          rr_in_ready !== 3'b000) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b data=%h sel=%0d rdy=%b want 1/a5a5a5a5/2/000",
                 c, rr_out_valid, rr_out_data, rr_out_sel, rr_in_ready);
      end
      step();
    end
    rr_out_ready = 1'b1;
    #1;
    total++;
    if (rr_in_ready !== 3'b001) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 001", rr_in_ready);
    end
    step();
    total++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 32'h0000_00C0) begin
      bad++;
      $display("FAIL bp_next_word: valid=%b sel=%0d data=%h want 1/0/000000c0",
               rr_out_valid, rr_out_sel, rr_out_data);
    end
    rr_in_valid = '0;
  endtask

  task automatic test_idle_drain();
    do_reset();
    fp_in_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    fp_in_valid = 4'b0100;
    step();
    fp_in_valid = 4'b0000;
    total++;
    if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd2 || fp_out_data !== 32'h2222_2222) begin
      bad++;
      $display("FAIL drain_load: valid=%b sel=%0d data=%h want 1/2/22222222",
               fp_out_valid, fp_out_sel, fp_out_data);
    end
    step();
    total++;
    if (fp_out_valid !== 1'b0 || fp_out_sel !== 2'd2 || fp_out_data !== 32'h2222_2222) begin
      bad++;
      $display("FAIL drain_idle: valid=%b sel=%0d data=%h want 0/2/22222222",
               fp_out_valid, fp_out_sel, fp_out_data);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rr_in_data  = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    rr_in_valid = 3'b111;
    step();
    step();
    total++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd1) begin
      bad++;
      $display("FAIL ar_pre: valid=%b sel=%0d want 1/1", rr_out_valid, rr_out_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 || rr_in_ready !== 3'b000) begin
      bad++;
      $display("FAIL ar_immediate: valid=%b data=%h rdy=%b want 0/0/000",
               rr_out_valid, rr_out_data, rr_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 32'h0000_00C0) begin
      bad++;
      $display("FAIL ar_first_grant: valid=%b sel=%0d data=%h want 1/0/000000c0",
               rr_out_valid, rr_out_sel, rr_out_data);
    end
    rr_in_valid = '0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    fp_in_data   = '0;
    fp_in_valid  = '0;
    fp_out_ready = 1'b1;
    rr_in_data   = '0;
    rr_in_valid  = '0;
    rr_out_ready = 1'b1;
    test_reset();
    test_fixed_priority();
    test_rr_rotation();
    test_backpressure();
    test_idle_drain();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
